// File: rtl/lane_scheduler_if.sv
// Lane scheduler bundle: junction sensors in, lamp drive and jam-counter
// enable out. The scheduler connects through the slave modport; whatever
// drives the sensors (junction model, bench) uses the master modport.
// Optional feature macro: EMERGENCY_OVERRIDE_EN adds emergency_req.
interface lane_scheduler_if #(
    parameter int NUM_LANES = 4
) ();
    localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

    logic [NUM_LANES-1:0] car_waiting;
    logic [NUM_LANES-1:0] lane_jam;
    logic                 check_other_lanes;
`ifdef EMERGENCY_OVERRIDE_EN
    logic [NUM_LANES-1:0] emergency_req;
`endif
    logic [NUM_LANES-1:0] green;
    logic [NUM_LANES-1:0] yellow;
    logic                 jam_counter_en;
    logic [LW-1:0]        cur_lane;

`ifdef EMERGENCY_OVERRIDE_EN
    modport master (
        output car_waiting, lane_jam, check_other_lanes, emergency_req,
        input  green, yellow, jam_counter_en, cur_lane
    );
    modport slave (
        input  car_waiting, lane_jam, check_other_lanes, emergency_req,
        output green, yellow, jam_counter_en, cur_lane
    );
`else
    modport master (
        output car_waiting, lane_jam, check_other_lanes,
        input  green, yellow, jam_counter_en, cur_lane
    );
    modport slave (
        input  car_waiting, lane_jam, check_other_lanes,
        output green, yellow, jam_counter_en, cur_lane
    );
`endif
endinterface

// File: rtl/lane_scheduler.sv
// Round-robin green-light scheduler for an N-lane junction.
// Sequence per grant: GREEN (GREEN_TIME cycles) -> optional JAM_HOLD while
// the granted lane is jammed -> YELLOW (YELLOW_TIME cycles) -> ALL_RED (1
// cycle) -> next grant or IDLE. All lamp outputs are registered.
// Optional feature macro: EMERGENCY_OVERRIDE_EN (emergency pre-emption of
// the round-robin order toward the lowest requesting lane).
module lane_scheduler #(
    parameter int NUM_LANES   = 4,
    parameter int GREEN_TIME  = 10,
    parameter int YELLOW_TIME = 3
) (
    input logic             clk,
    input logic             rst,
    lane_scheduler_if.slave bus
);
    localparam int LW   = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int TMAX = (GREEN_TIME > YELLOW_TIME) ? GREEN_TIME : YELLOW_TIME;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [TW-1:0] GREEN_LOAD  = TW'(GREEN_TIME - 1);
    localparam logic [TW-1:0] YELLOW_LOAD = TW'(YELLOW_TIME - 1);
    localparam logic [LW-1:0] LAST_LANE   = LW'(NUM_LANES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GREEN,
        S_JAM_HOLD,
        S_YELLOW,
        S_ALL_RED
`ifdef EMERGENCY_OVERRIDE_EN
        , S_EMERG
`endif
    } state_t;

    state_t               state_q;
    logic [TW-1:0]        timer_q;
    logic [LW-1:0]        cur_lane_q;
    logic [NUM_LANES-1:0] green_q;
    logic [NUM_LANES-1:0] yellow_q;
    logic                 jam_en_q;

    logic                 arb_found;
    logic [LW-1:0]        arb_lane;
    logic                 other_waiting;
    logic                 cur_jammed;

    function automatic logic [NUM_LANES-1:0] lane_onehot(input logic [LW-1:0] l);
        logic [NUM_LANES-1:0] v;
        v    = '0;
        v[l] = 1'b1;
        return v;
    endfunction

    // Round-robin search starting just after the current lane, current lane last
    always_comb begin
        int idx;
        arb_found = 1'b0;
        arb_lane  = cur_lane_q;
        idx       = 0;
        for (int i = 1; i <= NUM_LANES; i++) begin
            idx = (int'(cur_lane_q) + i) % NUM_LANES;
            if (!arb_found && bus.car_waiting[idx[LW-1:0]]) begin
                arb_found = 1'b1;
                arb_lane  = idx[LW-1:0];
            end
        end
    end

    // Decision inputs about the lane currently holding green
    always_comb begin
        other_waiting = |(bus.car_waiting & ~lane_onehot(cur_lane_q));
        cur_jammed    = bus.lane_jam[cur_lane_q];
    end

`ifdef EMERGENCY_OVERRIDE_EN
    logic          emg_act;
    logic [LW-1:0] emg_lane;

    // Lowest-index emergency request wins
    always_comb begin
        emg_act  = 1'b0;
        emg_lane = '0;
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            if (bus.emergency_req[i]) begin
                emg_act  = 1'b1;
                emg_lane = LW'(i);
            end
        end
    end
`endif

    // Junction FSM with registered lamp, enable and lane outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            timer_q    <= '0;
            cur_lane_q <= LAST_LANE;
            green_q    <= '0;
            yellow_q   <= '0;
            jam_en_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
`ifdef EMERGENCY_OVERRIDE_EN
                    if (emg_act) begin
                        state_q    <= S_EMERG;
                        cur_lane_q <= emg_lane;
                        green_q    <= lane_onehot(emg_lane);
                    end else
`endif
                    if (arb_found) begin
                        state_q    <= S_GREEN;
                        cur_lane_q <= arb_lane;
                        green_q    <= lane_onehot(arb_lane);
                        timer_q    <= GREEN_LOAD;
                    end
                end

                S_GREEN: begin
`ifdef EMERGENCY_OVERRIDE_EN
                    if (emg_act) begin
                        if (emg_lane == cur_lane_q) begin
                            state_q <= S_EMERG;
                        end else begin
                            state_q  <= S_YELLOW;
                            yellow_q <= green_q;
                            green_q  <= '0;
                            timer_q  <= YELLOW_LOAD;
                        end
                    end else
`endif
                    if (timer_q == '0) begin
                        if (cur_jammed) begin
                            state_q  <= S_JAM_HOLD;
                            jam_en_q <= 1'b1;
                        end else begin
                            state_q  <= S_YELLOW;
                            yellow_q <= green_q;
                            green_q  <= '0;
                            timer_q  <= YELLOW_LOAD;
                        end
                    end else begin
                        timer_q <= timer_q - TW'(1);
                    end
                end

                S_JAM_HOLD: begin
`ifdef EMERGENCY_OVERRIDE_EN
                    if (emg_act) begin
                        jam_en_q <= 1'b0;
                        if (emg_lane == cur_lane_q) begin
                            state_q <= S_EMERG;
                        end else begin
                            state_q  <= S_YELLOW;
                            yellow_q <= green_q;
                            green_q  <= '0;
                            timer_q  <= YELLOW_LOAD;
                        end
                    end else
`endif
                    // A cleared jam and a pulse with another lane waiting both
                    // end the hold; either alone suffices, together is one exit.
                    if (!cur_jammed || (bus.check_other_lanes && other_waiting)) begin
                        state_q  <= S_YELLOW;
                        jam_en_q <= 1'b0;
                        yellow_q <= green_q;
                        green_q  <= '0;
                        timer_q  <= YELLOW_LOAD;
                    end
                end

                S_YELLOW: begin
                    if (timer_q == '0) begin
                        state_q  <= S_ALL_RED;
                        yellow_q <= '0;
                    end else begin
                        timer_q <= timer_q - TW'(1);
                    end
                end

                S_ALL_RED: begin
`ifdef EMERGENCY_OVERRIDE_EN
                    if (emg_act) begin
                        state_q    <= S_EMERG;
                        cur_lane_q <= emg_lane;
                        green_q    <= lane_onehot(emg_lane);
                    end else
`endif
                    if (arb_found) begin
                        state_q    <= S_GREEN;
                        cur_lane_q <= arb_lane;
                        green_q    <= lane_onehot(arb_lane);
                        timer_q    <= GREEN_LOAD;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end

`ifdef EMERGENCY_OVERRIDE_EN
                // Green held on the emergency lane; timer is not running here
                S_EMERG: begin
                    if (!emg_act) begin
                        state_q <= S_GREEN;
                        timer_q <= GREEN_LOAD;
                    end else if (emg_lane != cur_lane_q) begin
                        state_q  <= S_YELLOW;
                        yellow_q <= green_q;
                        green_q  <= '0;
                        timer_q  <= YELLOW_LOAD;
                    end
                end
`endif

                default: begin
                    state_q  <= S_IDLE;
                    green_q  <= '0;
                    yellow_q <= '0;
                    jam_en_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.green          = green_q;
    assign bus.yellow         = yellow_q;
    assign bus.jam_counter_en = jam_en_q;
    assign bus.cur_lane       = cur_lane_q;

endmodule

// File: tb/tb_lane_scheduler.sv
// Bench for lane_scheduler: a phase/elapsed-count model of the junction
// rules checked every cycle, a jam-counter model producing
// check_other_lanes, and directed scenarios with literal expectations.
`timescale 1ns/1ps
module tb_lane_scheduler;
    localparam int N  = 4;
    localparam int GT = 10;
    localparam int YT = 3;

    localparam int PH_IDLE  = 0;
    localparam int PH_GREEN = 1;
    localparam int PH_JAM   = 2;
    localparam int PH_YEL   = 3;
    localparam int PH_RED   = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lane_scheduler_if #(.NUM_LANES(N)) bus ();

    lane_scheduler #(
        .NUM_LANES  (N),
        .GREEN_TIME (GT),
        .YELLOW_TIME(YT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    int m_phase = PH_IDLE;
    int m_cnt   = 0;
    int m_lane  = N - 1;
    int nl;
    int jc      = 0;
    int waited;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic lamps(input string name, input logic [N-1:0] g, input logic [N-1:0] y, input logic j);
        chk({name, ".green"}, 32'(bus.green), 32'(g));
        chk({name, ".yellow"}, 32'(bus.yellow), 32'(y));
        chk({name, ".jam_en"}, 32'(bus.jam_counter_en), 32'(j));
    endtask

    // First waiting lane after 'from', wrapping, 'from' itself last; -1 if none
    function automatic int next_lane(input int from, input logic [N-1:0] w);
        for (int k = 1; k <= N; k++) begin
            if (w[(from + k) % N]) return (from + k) % N;
        end
        return -1;
    endfunction

    // Junction model: advances on each edge from the inputs held across it
    always @(posedge clk) begin
        if (rst) begin
            m_phase = PH_IDLE;
            m_lane  = N - 1;
            m_cnt   = 0;
        end else begin
            case (m_phase)
                PH_IDLE: begin
                    nl = next_lane(m_lane, bus.car_waiting);
                    if (nl >= 0) begin
                        m_lane  = nl;
                        m_phase = PH_GREEN;
                        m_cnt   = 0;
                    end
                end
                PH_GREEN: begin
                    m_cnt++;
                    if (m_cnt == GT) begin
                        m_phase = bus.lane_jam[m_lane] ? PH_JAM : PH_YEL;
                        m_cnt   = 0;
                    end
                end
                PH_JAM: begin
                    if (!bus.lane_jam[m_lane] ||
                        (bus.check_other_lanes && ((bus.car_waiting & ~(N'(1) << m_lane)) != '0))) begin
                        m_phase = PH_YEL;
                        m_cnt   = 0;
                    end
                end
                PH_YEL: begin
                    m_cnt++;
                    if (m_cnt == YT) m_phase = PH_RED;
                end
                default: begin
                    nl = next_lane(m_lane, bus.car_waiting);
                    if (nl >= 0) begin
                        m_lane  = nl;
                        m_phase = PH_GREEN;
                        m_cnt   = 0;
                    end else begin
                        m_phase = PH_IDLE;
                    end
                end
            endcase
        end
    end

    // Jam counter: one check_other_lanes pulse per 15 cycles of jam_counter_en
    always @(negedge clk) begin
        if (rst || bus.jam_counter_en !== 1'b1) begin
            jc = 0;
            bus.check_other_lanes = 1'b0;
        end else begin
            jc++;
            if (jc == 15) begin
                bus.check_other_lanes = 1'b1;
                jc = 0;
            end else begin
                bus.check_other_lanes = 1'b0;
            end
        end
    end

    // Every-cycle comparison against the model plus lamp invariants
    always @(negedge clk) begin
        logic [N-1:0] eg, ey, gy;
        if (chk_en) begin
            eg = (m_phase == PH_GREEN || m_phase == PH_JAM) ? (N'(1) << m_lane) : '0;
            ey = (m_phase == PH_YEL) ? (N'(1) << m_lane) : '0;
            chk("model.green", 32'(bus.green), 32'(eg));
            chk("model.yellow", 32'(bus.yellow), 32'(ey));
            chk("model.jam_en", 32'(bus.jam_counter_en), 32'(m_phase == PH_JAM));
            chk("model.cur_lane", 32'(bus.cur_lane), 32'(m_lane));
            gy = bus.green | bus.yellow;
            chk("inv.onehot0", 32'((gy & (gy - N'(1))) == '0), 32'(1));
            chk("inv.jam_needs_green", 32'(!bus.jam_counter_en || (bus.green != '0)), 32'(1));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] eg, ey;
        bus.car_waiting = '0;
        bus.lane_jam    = '0;
`ifdef EMERGENCY_OVERRIDE_EN
        bus.emergency_req = '0;
`endif
        rst = 1'b1;

        // Reset held 5 cycles with no cars
        step(1);
        chk_en = 1'b1;
        step(4);
        lamps("reset", 4'b0000, 4'b0000, 1'b0);
        chk("reset.cur_lane", 32'(bus.cur_lane), 32'd3);
        rst = 1'b0;

        // Lanes 0 and 2 waiting: green0 x10, yellow0 x3, all-red x1, green2
        bus.car_waiting = 4'b0101;
        for (int k = 1; k <= 15; k++) begin
            step(1);
            eg = (k <= 10) ? 4'b0001 : (k == 15) ? 4'b0100 : 4'b0000;
            ey = (k >= 11 && k <= 13) ? 4'b0001 : 4'b0000;
            if (k == 1 || k == 10 || k == 11 || k == 13 || k == 14 || k == 15)
                lamps($sformatf("rr.k%0d", k), eg, ey, 1'b0);
        end
        chk("rr.cur_lane", 32'(bus.cur_lane), 32'd2);

        // Reset during green
        rst = 1'b1;
        step(1);
        lamps("rst_green", 4'b0000, 4'b0000, 1'b0);
        chk("rst_green.cur_lane", 32'(bus.cur_lane), 32'd3);
        rst = 1'b0;
        bus.car_waiting = '0;

        // Jammed lane 1 alone: hold green across counter pulses
        bus.car_waiting = 4'b0010;
        bus.lane_jam    = 4'b0010;
        step(10);
        lamps("jam.g10", 4'b0010, 4'b0000, 1'b0);
        step(1);
        lamps("jam.enter", 4'b0010, 4'b0000, 1'b1);
        step(35);
        lamps("jam.held", 4'b0010, 4'b0000, 1'b1);
        // Lane 3 arrives: handover on the next counter pulse, 10 cycles away
        bus.car_waiting = 4'b1010;
        waited = 0;
        while (bus.yellow == '0 && waited < 30) begin
            step(1);
            waited++;
        end
        chk("jam.pulse_latency", 32'(waited), 32'd10);
        lamps("jam.exit", 4'b0000, 4'b0010, 1'b0);
        bus.lane_jam = '0;
        step(4);
        lamps("jam.next_grant", 4'b1000, 4'b0000, 1'b0);
        chk("jam.next_lane", 32'(bus.cur_lane), 32'd3);

        // Jam clears while held
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        bus.car_waiting = 4'b0001;
        bus.lane_jam    = 4'b0001;
        step(11);
        lamps("clr.hold", 4'b0001, 4'b0000, 1'b1);
        step(3);
        bus.lane_jam = '0;
        step(1);
        lamps("clr.yellow", 4'b0000, 4'b0001, 1'b0);

        // Wrap-around from lane 3 straight after reset
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        bus.car_waiting = 4'b1001;
        step(1);
        lamps("wrap.reset", 4'b0001, 4'b0000, 1'b0);

        // Wrap-around after a real grant of lane 3
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        bus.car_waiting = 4'b1000;
        step(1);
        lamps("wrap.g3", 4'b1000, 4'b0000, 1'b0);
        bus.car_waiting = 4'b1001;
        step(14);
        lamps("wrap.g0", 4'b0001, 4'b0000, 1'b0);
        chk("wrap.cur_lane", 32'(bus.cur_lane), 32'd0);

        // Reset during yellow
        step(10);
        lamps("rst_yel.pre", 4'b0000, 4'b0001, 1'b0);
        rst = 1'b1;
        step(1);
        lamps("rst_yel", 4'b0000, 4'b0000, 1'b0);
        chk("rst_yel.cur_lane", 32'(bus.cur_lane), 32'd3);
        rst = 1'b0;

        // Reset during jam hold
        bus.car_waiting = 4'b0010;
        bus.lane_jam    = 4'b0010;
        step(11);
        lamps("rst_jam.pre", 4'b0010, 4'b0000, 1'b1);
        rst = 1'b1;
        step(1);
        lamps("rst_jam", 4'b0000, 4'b0000, 1'b0);
        chk("rst_jam.cur_lane", 32'(bus.cur_lane), 32'd3);
        rst = 1'b0;
        bus.car_waiting = '0;
        bus.lane_jam    = '0;
        step(2);

`ifdef EMERGENCY_OVERRIDE_EN
        // Emergency on lane 2 during green0: yellow0 x3, all-red, green2 held
        chk_en = 1'b0;
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        bus.car_waiting = 4'b0001;
        step(2);
        lamps("emg.g0", 4'b0001, 4'b0000, 1'b0);
        bus.emergency_req = 4'b0100;
        step(1);
        lamps("emg.y1", 4'b0000, 4'b0001, 1'b0);
        step(2);
        lamps("emg.y3", 4'b0000, 4'b0001, 1'b0);
        step(1);
        lamps("emg.red", 4'b0000, 4'b0000, 1'b0);
        step(1);
        lamps("emg.g2", 4'b0100, 4'b0000, 1'b0);
        step(20);
        lamps("emg.held", 4'b0100, 4'b0000, 1'b0);
        bus.emergency_req = '0;
        bus.car_waiting   = '0;
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk_en = 1'b1;
        step(2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
